mmio_bridge: RTL and testbench

- Parametrised successor to the core's single-cycle MMIO tap: converts a memory-stage MMIO request into a multi-channel, ready-handshaked peripheral bus.
- Sits between the memory stage and NUM_SLAVES peripherals.
- Stalls the pipeline until the peripheral answers, a decode error is detected, or a timeout fires.
- Replaces the hard-wired MEM_RDY=1 assumption with a real wait-state and error path.

---
 rtl/mmio_pkg.sv | 18 +
 rtl/mmio_decode.sv | 36 +++
 rtl/mmio_bridge.sv | 184 ++++++++++++++++++
 tb/tb_mmio_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: definitions shared by the MMIO bridge and the address decoder.
//   state_t         - bridge FSM states (IDLE, ACCESS, RESP)
//   MMIO_DATA_W     - default data width of the peripheral bus
//   DEF_MMIO_BASE   - default base of the MMIO window
//   DEF_MMIO_LIMIT  - default inclusive top of the MMIO window
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int          MMIO_DATA_W    = 32;
    localparam logic [31:0] DEF_MMIO_BASE  = 32'h1000_0000;
    localparam logic [31:0] DEF_MMIO_LIMIT = 32'h1FFF_FFFF;

endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: purely combinational MMIO window decoder.
//   req     in   request qualifier
//   addr    in   byte address
//   in_win  out  req & address inside [MMIO_BASE, MMIO_LIMIT]
//   idx     out  slot number (addr - MMIO_BASE) >> SLOT_BITS
//   offset  out  byte offset inside the slot
//   slot_ok out  in_win & idx addresses an existing channel
import mmio_pkg::*;

module mmio_decode #(
    parameter int                ADDR_W     = 32,
    parameter int                NUM_SLAVES = 4,
    parameter int                SLOT_BITS  = 12,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter logic [ADDR_W-1:0] MMIO_LIMIT = DEF_MMIO_LIMIT
) (
    input  logic                        req,
    input  logic [ADDR_W-1:0]           addr,
    output logic                        in_win,
    output logic [ADDR_W-SLOT_BITS-1:0] idx,
    output logic [SLOT_BITS-1:0]        offset,
    output logic                        slot_ok
);

    localparam int IDX_W = ADDR_W - SLOT_BITS;

    logic [ADDR_W-1:0] rel;

    // Unsigned, full-width compare and subtract.
    assign rel     = addr - MMIO_BASE;
    assign in_win  = req && (addr >= MMIO_BASE) && (addr <= MMIO_LIMIT);
    assign idx     = rel[ADDR_W-1:SLOT_BITS];
    assign offset  = rel[SLOT_BITS-1:0];
    assign slot_ok = in_win && (idx < IDX_W'(NUM_SLAVES));

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: turns a memory-stage MMIO request into an access on a
// multi-channel ready-handshaked peripheral bus, stalling the pipeline
// until the peripheral answers, the slot decode fails or a timeout fires.
//   clk, reset            clock, asynchronous active-high reset
//   cpu_req/wr/addr/wdata/be  request from the memory stage (held while stalled)
//   cpu_stall             freeze pipeline (combinational, covers request cycle)
//   cpu_rsp_valid         one-cycle response strobe (RESP state)
//   cpu_rdata, cpu_err    response payload, held until the next response
//   s_cs/wr/rd/addr/wdata/be  registered bus outputs, constant during ACCESS
//   s_rdy, s_rdata        per-channel completion and packed read data
//   err_count             saturating count of error responses
//   state                 FSM state, exported for observation
// Handshake: an access is one ACCESS period with s_cs one-hot; it completes
// on the first cycle where s_rdy of the selected channel is high. s_rdy of
// other channels is ignored. The response is the single RESP cycle after.
import mmio_pkg::*;

module mmio_bridge #(
    parameter int                NUM_SLAVES = 4,
    parameter int                DATA_W     = MMIO_DATA_W,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] MMIO_BASE  = DEF_MMIO_BASE,
    parameter logic [ADDR_W-1:0] MMIO_LIMIT = DEF_MMIO_LIMIT,
    parameter int                SLOT_BITS  = 12,
    parameter int                TIMEOUT    = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cpu_req,
    input  logic                         cpu_wr,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic [DATA_W/8-1:0]          cpu_be,
    output logic                         cpu_stall,
    output logic                         cpu_rsp_valid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_err,
    output logic [NUM_SLAVES-1:0]        s_cs,
    output logic                         s_wr,
    output logic                         s_rd,
    output logic [SLOT_BITS-1:0]         s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_be,
    input  logic [NUM_SLAVES-1:0]        s_rdy,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic [7:0]                   err_count,
    output state_t                       state
);

    localparam int IDX_W  = ADDR_W - SLOT_BITS;
    localparam int TCNT_W = $clog2(TIMEOUT);
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT - 1);

    logic                  in_win;
    logic                  slot_ok;
    logic [IDX_W-1:0]      idx;
    logic [SLOT_BITS-1:0]  offset;

    state_t                state_n;
    logic [TCNT_W-1:0]     tcnt;
    logic [NUM_SLAVES-1:0] cs_n;
    logic                  hit;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  accept;
    logic                  rsp_load;
    logic                  rsp_err_n;
    logic [DATA_W-1:0]     rsp_rdata_n;

    mmio_decode #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES),
        .SLOT_BITS  (SLOT_BITS),
        .MMIO_BASE  (MMIO_BASE),
        .MMIO_LIMIT (MMIO_LIMIT)
    ) u_decode (
        .req     (cpu_req),
        .addr    (cpu_addr),
        .in_win  (in_win),
        .idx     (idx),
        .offset  (offset),
        .slot_ok (slot_ok)
    );

    // Reset gates the stall so every output is 0 while reset is held.
    assign cpu_stall     = in_win && (state != RESP) && !reset;
    assign cpu_rsp_valid = (state == RESP);

    // One-hot select for the decoded slot, and the read-data / ready
    // selection driven by the registered select.
    always_comb begin
        cs_n      = '0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            cs_n[i] = (idx == IDX_W'(i));
            if (s_cs[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
        hit = |(s_rdy & s_cs);
    end

    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        rsp_load    = 1'b0;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
        case (state)
            IDLE: begin
                if (slot_ok) begin
                    state_n = ACCESS;
                    accept  = 1'b1;
                end else if (in_win) begin
                    state_n   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 1'b1;
                end
            end
            ACCESS: begin
                // A ready in the timeout cycle still counts as success.
                if (hit) begin
                    state_n     = RESP;
                    rsp_load    = 1'b1;
                    rsp_rdata_n = s_wr ? '0 : sel_rdata;
                end else if (tcnt == TLAST) begin
                    state_n   = RESP;
                    rsp_load  = 1'b1;
                    rsp_err_n = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt      <= '0;
            s_cs      <= '0;
            s_wr      <= 1'b0;
            s_rd      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_be      <= '0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            err_count <= '0;
        end else begin
            if (accept) begin
                tcnt    <= '0;
                s_cs    <= cs_n;
                s_wr    <= cpu_wr;
                s_rd    <= !cpu_wr;
                s_addr  <= offset;
                s_wdata <= cpu_wdata;
                s_be    <= cpu_be;
            end else if (state == ACCESS) begin
                if (state_n != ACCESS) begin
                    s_cs    <= '0;
                    s_wr    <= 1'b0;
                    s_rd    <= 1'b0;
                    s_addr  <= '0;
                    s_wdata <= '0;
                    s_be    <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            if (rsp_load) begin
                cpu_rdata <= rsp_rdata_n;
                cpu_err   <= rsp_err_n;
                if (rsp_err_n && (err_count != 8'hFF)) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed bench for mmio_bridge (default parameters).
import mmio_pkg::*;

module tb_mmio_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic         cpu_wr;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_be;
    logic         cpu_stall;
    logic         cpu_rsp_valid;
    logic [31:0]  cpu_rdata;
    logic         cpu_err;
    logic [3:0]   s_cs;
    logic         s_wr;
    logic         s_rd;
    logic [11:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_be;
    logic [3:0]   s_rdy;
    logic [127:0] s_rdata;
    logic [7:0]   err_count;
    state_t       st;

    int checks   = 0;
    int failures = 0;
    int exp_errs = 0;
    logic [31:0] exp_q[$];

    // bus snapshot from the first ACCESS cycle, plus response observations
    logic        b_wr, b_rd, bus_changed;
    logic [11:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_be;
    logic        r_err, r_stall;
    logic [3:0]  r_cs;

    mmio_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_wr        (cpu_wr),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_be        (cpu_be),
        .cpu_stall     (cpu_stall),
        .cpu_rsp_valid (cpu_rsp_valid),
        .cpu_rdata     (cpu_rdata),
        .cpu_err       (cpu_err),
        .s_cs          (s_cs),
        .s_wr          (s_wr),
        .s_rd          (s_rd),
        .s_addr        (s_addr),
        .s_wdata       (s_wdata),
        .s_be          (s_be),
        .s_rdy         (s_rdy),
        .s_rdata       (s_rdata),
        .err_count     (err_count),
        .state         (st)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Driver: issue one request starting at posedge+1 and return at posedge+1
    // after the response. ch<0 means no channel ever answers; waits is the
    // number of ACCESS cycles before s_rdy[ch]; noise is driven on s_rdy
    // throughout the access.
    task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int ch, input int waits,
                           input logic [31:0] rdata, input logic [3:0] noise,
                           output int stall_cyc, output int rsp_cyc, output int acc_cyc,
                           output logic [3:0] cs_seen);
        logic got_rsp;
        logic first;
        stall_cyc   = 0;
        rsp_cyc     = -1;
        acc_cyc     = 0;
        cs_seen     = '0;
        got_rsp     = 1'b0;
        first       = 1'b1;
        bus_changed = 1'b0;
        cpu_req   = 1'b1;
        cpu_wr    = wr;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_be    = be;
        for (int c = 0; c < 4; c++) begin
            s_rdata[c*32 +: 32] = (c == ch) ? rdata : (32'hDEAD_0000 | 32'(c));
        end
        for (int cyc = 0; cyc < 200 && !got_rsp; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            s_rdy = '0;
            if (cyc >= 1) s_rdy = noise;
            if (ch >= 0 && cyc == waits + 1) s_rdy[ch] = 1'b1;
            @(negedge clk);
            if (cpu_stall) stall_cyc++;
            cs_seen = cs_seen | s_cs;
            if (s_cs != 0) begin
                acc_cyc++;
                if (first) begin
                    b_wr = s_wr; b_rd = s_rd; b_addr = s_addr; b_wdata = s_wdata; b_be = s_be;
                    first = 1'b0;
                end else if ({b_wr, b_rd, b_addr, b_wdata, b_be} !== {s_wr, s_rd, s_addr, s_wdata, s_be}) begin
                    bus_changed = 1'b1;
                end
            end
            if (cpu_rsp_valid) begin
                got_rsp = 1'b1;
                rsp_cyc = cyc;
                r_err   = cpu_err;
                r_cs    = s_cs;
                r_stall = cpu_stall;
                if (exp_q.size() > 0) check("rsp_rdata", cpu_rdata, exp_q.pop_front());
            end
        end
        if (!got_rsp) check("rsp_timeout", 0, 1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        s_rdy   = '0;
    endtask

    int stl, rsp, acc, pulses;
    logic [3:0] cs;
    logic [31:0] oow [3];
    logic [7:0] mid_cnt;

    initial begin
        reset = 1'b1; cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0;
        s_rdy = 0; s_rdata = 0;
        @(negedge clk);
        check("reset_state", 64'(st), 64'(IDLE));
        check("reset_outs", {cpu_stall, cpu_rsp_valid, cpu_rdata, cpu_err, s_cs, s_wr, s_rd, err_count}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // store, zero wait states
        exp_q.push_back(32'h0);
        run_req(1'b1, 32'h1000_0008, 32'hCAFE_F00D, 4'hF, 0, 0, 32'h0, 4'h0, stl, rsp, acc, cs);
        check("st_stall", stl, 2);
        check("st_rsp_cyc", rsp, 2);
        check("st_cs", cs, 4'b0001);
        check("st_bus", {b_wr, b_rd, b_addr, b_wdata, b_be}, {1'b1, 1'b0, 12'h008, 32'hCAFE_F00D, 4'hF});
        check("st_err", r_err, 0);
        check("st_rsp_stall_cs", {r_stall, r_cs}, 0);

        // load, 5 wait states on slave 3
        exp_q.push_back(32'h1234_5678);
        run_req(1'b0, 32'h1000_3010, 32'h0, 4'h3, 3, 5, 32'h1234_5678, 4'h0, stl, rsp, acc, cs);
        check("ld_stall", stl, 7);
        check("ld_rsp_cyc", rsp, 7);
        check("ld_cs", cs, 4'b1000);
        check("ld_bus", {b_wr, b_rd, b_addr, b_be}, {1'b0, 1'b1, 12'h010, 4'h3});
        check("ld_bus_stable", bus_changed, 0);
        check("ld_err", r_err, 0);
        @(negedge clk);
        check("ld_hold", {cpu_rsp_valid, cpu_rdata, cpu_err}, {1'b0, 32'h1234_5678, 1'b0});
        @(posedge clk); #1;

        // decode error: idx 4
        exp_q.push_back(32'h0);
        exp_errs = sat_inc(exp_errs);
        run_req(1'b0, 32'h1000_4000, 32'h0, 4'hF, -1, 0, 32'h0, 4'h0, stl, rsp, acc, cs);
        check("dec_rsp_cyc", rsp, 1);
        check("dec_cs", cs, 0);
        check("dec_err", r_err, 1);
        check("dec_errcnt", err_count, exp_errs);

        // timeout on slave 1
        exp_q.push_back(32'h0);
        exp_errs = sat_inc(exp_errs);
        run_req(1'b0, 32'h1000_1000, 32'h0, 4'hF, -1, 0, 32'h5555_AAAA, 4'h0, stl, rsp, acc, cs);
        check("to_acc_cycles", acc, 64);
        check("to_rsp_cyc", rsp, 65);
        check("to_cs", cs, 4'b0010);
        check("to_err_cs", {r_err, r_cs}, {1'b1, 4'b0000});
        check("to_errcnt", err_count, exp_errs);

        // ready on unselected channels must not end the access
        exp_q.push_back(32'hA5A5_5A5A);
        run_req(1'b0, 32'h1000_1ABC, 32'h0, 4'hF, 1, 3, 32'hA5A5_5A5A, 4'b1101, stl, rsp, acc, cs);
        check("noise_rsp_cyc", rsp, 5);
        check("noise_addr_err", {b_addr, r_err}, {12'hABC, 1'b0});

        // window edges and top slot of the window
        oow[0] = 32'h0000_0100; oow[1] = 32'h0FFF_FFFC; oow[2] = 32'h2000_0000;
        for (int k = 0; k < 3; k++) begin
            cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = oow[k];
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                check($sformatf("oow%0d", k), {cpu_stall, s_cs, cpu_rsp_valid}, 0);
                @(posedge clk); #1;
            end
            cpu_req = 1'b0;
        end
        exp_q.push_back(32'h0);
        exp_errs = sat_inc(exp_errs);
        run_req(1'b1, 32'h1FFF_FFFC, 32'h1, 4'hF, -1, 0, 32'h0, 4'h0, stl, rsp, acc, cs);
        check("top_dec", {rsp[7:0], cs, r_err}, {8'd1, 4'b0000, 1'b1});
        check("top_errcnt", err_count, exp_errs);

        // reset in the middle of an access to slave 2
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h1000_2004;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_cs", s_cs, 4'b0100);
        #2;
        reset = 1'b1; cpu_req = 1'b0;
        exp_errs = 0;
        #1;
        check("rst_cs_now", {s_cs, s_rd}, 0);
        check("rst_state_now", 64'(st), 64'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (cpu_rsp_valid) pulses++;
            @(posedge clk); #1;
        end
        check("rst_no_rsp", pulses, 0);
        check("rst_errcnt", err_count, 0);

        // 260 back-to-back decode errors: counter saturates
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 32'h1000_4000;
        pulses = 0; mid_cnt = 0;
        for (int c = 0; c < 520; c++) begin
            @(negedge clk);
            if (cpu_rsp_valid) begin
                pulses++;
                exp_errs = sat_inc(exp_errs);
                if (pulses == 100) check("sat_mid", err_count, exp_errs);
                if (pulses == 255) mid_cnt = err_count;
            end
            @(posedge clk); #1;
        end
        cpu_req = 1'b0;
        check("sat_pulses", pulses, 260);
        check("sat_at_255", mid_cnt, 8'hFF);
        check("sat_final", err_count, exp_errs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
